// File: rtl/game_flow_controller_if.sv
// rtl/game_flow_controller_if.sv - link between game_flow_controller and the collision/powerup detector
// Signals:
//   game_active                  controller -> detector enable; low clears the detector's sticky flags
//   is_collision                 detector -> controller sticky obstacle-collision flag
//   is_speed_powerup_collision   detector -> controller sticky speed-pickup flag
//   is_shield_powerup_collision  detector -> controller sticky shield-pickup flag
// Modports: master (flow controller), slave (detector).
interface game_flow_controller_if;
  logic game_active;
  logic is_collision;
  logic is_speed_powerup_collision;
  logic is_shield_powerup_collision;

  modport master (
    output game_active,
    input  is_collision,
    input  is_speed_powerup_collision,
    input  is_shield_powerup_collision
  );

  modport slave (
    input  game_active,
    output is_collision,
    output is_speed_powerup_collision,
    output is_shield_powerup_collision
  );
endinterface

// File: rtl/game_flow_controller.sv
// rtl/game_flow_controller.sv - game sequencing: owns detector enable, powerup timers, shield absorption, game over
// Ports:
//   clock_100mhz   system clock
//   reset_n        asynchronous active-low reset
//   start_pulse    one-cycle start/restart request (debounced)
//   det            detector link (master): game_active out, sticky flags in
//   speed_active   speed boost in effect (speed timer nonzero)
//   shield_active  shield in effect (shield timer nonzero)
//   game_over      high while in GAME_OVER
//   hits_absorbed  collisions absorbed by the shield, saturating at 255
module game_flow_controller #(
  parameter int unsigned SPEED_CYCLES  = 300000000,
  parameter int unsigned SHIELD_CYCLES = 500000000,
  parameter int unsigned REARM_CYCLES  = 2,
  parameter int unsigned TIMER_W       = 32
) (
  input  logic                   clock_100mhz,
  input  logic                   reset_n,
  input  logic                   start_pulse,
  game_flow_controller_if.master det,
  output logic                   speed_active,
  output logic                   shield_active,
  output logic                   game_over,
  output logic [7:0]             hits_absorbed
);

  localparam int unsigned REARM_W = $clog2(REARM_CYCLES);
  localparam logic [REARM_W-1:0] REARM_LOAD  = REARM_W'(REARM_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SPEED_LOAD  = TIMER_W'(SPEED_CYCLES);
  localparam logic [TIMER_W-1:0] SHIELD_LOAD = TIMER_W'(SHIELD_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, REARM, GAME_OVER} state_t;

  state_t               state_q, state_d;
  logic [REARM_W-1:0]   rearm_q, rearm_d;
  logic [7:0]           hits_d;
  logic [TIMER_W-1:0]   speed_q, speed_d;
  logic [TIMER_W-1:0]   shield_q, shield_d;
  logic                 rst_done_q;

  // Control strobes from the FSM to the timer blocks
  logic timers_clear;
  logic timers_tick;
  logic speed_load;
  logic shield_load;
  logic shield_consume;

  logic start_ok;
  logic any_event;
  logic shield_on;

  // The first edge after reset release never accepts a start request
  assign start_ok  = start_pulse & rst_done_q;
  assign any_event = det.is_collision | det.is_speed_powerup_collision |
                     det.is_shield_powerup_collision;
  // Shield state before this cycle's pickups decides survival
  assign shield_on = (shield_q != '0);

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      rearm_q         <= '0;
      hits_absorbed   <= '0;
      rst_done_q      <= 1'b0;
      det.game_active <= 1'b0;
      game_over       <= 1'b0;
    end else begin
      state_q         <= state_d;
      rearm_q         <= rearm_d;
      hits_absorbed   <= hits_d;
      rst_done_q      <= 1'b1;
      det.game_active <= (state_d == RUN);
      game_over       <= (state_d == GAME_OVER);
    end
  end

  always_comb begin
    state_d        = state_q;
    rearm_d        = rearm_q;
    hits_d         = hits_absorbed;
    timers_clear   = 1'b0;
    timers_tick    = 1'b0;
    speed_load     = 1'b0;
    shield_load    = 1'b0;
    shield_consume = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d      = RUN;
          timers_clear = 1'b1;
          hits_d       = '0;
        end
      end
      RUN: begin
        timers_tick = 1'b1;
        if (det.is_collision && !shield_on) begin
          // Unshielded hit ends the game; pickups in the same cycle are dropped
          state_d      = GAME_OVER;
          timers_clear = 1'b1;
        end else if (any_event) begin
          state_d        = REARM;
          rearm_d        = REARM_LOAD;
          speed_load     = det.is_speed_powerup_collision;
          shield_load    = det.is_shield_powerup_collision;
          shield_consume = det.is_collision;
          if (det.is_collision && (hits_absorbed != 8'hFF)) begin
            hits_d = hits_absorbed + 8'd1;
          end
        end
      end
      REARM: begin
        timers_tick = 1'b1;
        if (rearm_q == '0) begin
          state_d = RUN;
        end else begin
          rearm_d = rearm_q - REARM_W'(1);
        end
      end
      GAME_OVER: begin
        timers_clear = 1'b1;
        if (start_ok) begin
          state_d = RUN;
          hits_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Speed timer: a load wins over the decrement of the same cycle
  always_comb begin
    speed_d = speed_q;
    if (timers_clear) begin
      speed_d = '0;
    end else if (speed_load) begin
      speed_d = SPEED_LOAD;
    end else if (timers_tick && (speed_q != '0)) begin
      speed_d = speed_q - TIMER_ONE;
    end
  end

  // Shield timer: a pickup reload wins over consumption by a collision
  always_comb begin
    shield_d = shield_q;
    if (timers_clear) begin
      shield_d = '0;
    end else if (shield_load) begin
      shield_d = SHIELD_LOAD;
    end else if (shield_consume) begin
      shield_d = '0;
    end else if (timers_tick && (shield_q != '0)) begin
      shield_d = shield_q - TIMER_ONE;
    end
  end

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      speed_q       <= '0;
      shield_q      <= '0;
      speed_active  <= 1'b0;
      shield_active <= 1'b0;
    end else begin
      speed_q       <= speed_d;
      shield_q      <= shield_d;
      speed_active  <= (speed_d != '0);
      shield_active <= (shield_d != '0);
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// tb/tb_game_flow_controller.sv - randomized scoreboard bench for game_flow_controller
module tb_game_flow_controller;

  localparam int SPEED  = 10;
  localparam int SHIELD = 20;
  localparam int REARM  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       speed_active;
  logic       shield_active;
  logic       game_over;
  logic [7:0] hits;

  game_flow_controller_if det();

  game_flow_controller #(
    .SPEED_CYCLES (SPEED),
    .SHIELD_CYCLES(SHIELD),
    .REARM_CYCLES (REARM),
    .TIMER_W      (8)
  ) dut (
    .clock_100mhz (clk),
    .reset_n      (rst_n),
    .start_pulse  (start),
    .det          (det),
    .speed_active (speed_active),
    .shield_active(shield_active),
    .game_over    (game_over),
    .hits_absorbed(hits)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected {game_active, speed_active, shield_active, game_over, hits} after each edge
  logic [11:0] exp_q[$];

  // Reference model of the game rules
  typedef enum {M_IDLE, M_PLAY, M_COOLDOWN, M_OVER} mode_t;
  mode_t m_mode = M_IDLE;
  int m_spd = 0, m_shd = 0, m_hits = 0, m_low_left = 0, m_since_rst = 0;
  bit fc = 0, fs = 0, fh = 0;

  function automatic int dec0(input int v);
    return (v > 0) ? v - 1 : 0;
  endfunction

  function automatic logic [11:0] model_out();
    logic [7:0] h;
    h = 8'(m_hits);
    return {m_mode == M_PLAY, m_spd != 0, m_shd != 0, m_mode == M_OVER, h};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_spd = 0; m_shd = 0; m_hits = 0; m_low_left = 0; m_since_rst = 0;
  endtask

  task automatic model_edge(input bit st);
    bit first;
    if (!rst_n) begin
      model_reset();
      return;
    end
    first = (m_since_rst == 0);
    if (m_since_rst < 1000) m_since_rst++;
    case (m_mode)
      M_IDLE: if (st && !first) begin
        m_mode = M_PLAY; m_spd = 0; m_shd = 0; m_hits = 0;
      end
      M_PLAY: begin
        if (fc && m_shd == 0) begin
          m_mode = M_OVER; m_spd = 0; m_shd = 0;
        end else if (fc || fs || fh) begin
          m_spd = fs ? SPEED : dec0(m_spd);
          m_shd = fh ? SHIELD : (fc ? 0 : dec0(m_shd));
          if (fc) m_hits = (m_hits < 255) ? m_hits + 1 : 255;
          m_mode = M_COOLDOWN; m_low_left = REARM;
        end else begin
          m_spd = dec0(m_spd); m_shd = dec0(m_shd);
        end
      end
      M_COOLDOWN: begin
        m_spd = dec0(m_spd); m_shd = dec0(m_shd);
        m_low_left--;
        if (m_low_left == 0) m_mode = M_PLAY;
      end
      M_OVER: begin
        m_spd = 0; m_shd = 0;
        if (st && !first) begin
          m_mode = M_PLAY; m_hits = 0;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // One clock of stimulus; entered and left just after a falling edge.
  // The detector model clears its flags while game_active is low.
  task automatic step(input bit st, input bit rc, input bit rs, input bit rh);
    bit ga_now;
    ga_now = (m_mode == M_PLAY);
    if (!ga_now) begin
      fc = 0; fs = 0; fh = 0;
    end else begin
      fc = fc | rc; fs = fs | rs; fh = fh | rh;
    end
    start = st;
    det.is_collision = fc;
    det.is_speed_powerup_collision = fs;
    det.is_shield_powerup_collision = fh;
    model_edge(st);
    exp_q.push_back(model_out());
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock
  task automatic do_reset(input int hold);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({det.game_active, speed_active, shield_active, game_over, hits} != 12'h000) begin
      errors++;
      $display("FAIL async_reset got=%h want=000 t=%0t",
               {det.game_active, speed_active, shield_active, game_over, hits}, $time);
    end
    model_reset();
    fc = 0; fs = 0; fh = 0;
    repeat (hold) step(0, 0, 0, 0);
    rst_n = 1'b1;
    step(1, 0, 0, 0);
  endtask

  // Monitor: compares every presented output cycle against the scoreboard
  always @(negedge clk) begin
    logic [11:0] exp_v;
    logic [11:0] act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {det.game_active, speed_active, shield_active, game_over, hits};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t got ga=%b spd=%b shd=%b go=%b hits=%0d want ga=%b spd=%b shd=%b go=%b hits=%0d",
                 $time, act_v[11], act_v[10], act_v[9], act_v[8], act_v[7:0],
                 exp_v[11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
      end
    end
  end

  initial begin
    det.is_collision = 1'b0;
    det.is_speed_powerup_collision = 1'b0;
    det.is_shield_powerup_collision = 1'b0;
    @(negedge clk);
    #1;
    idle(3);
    rst_n = 1'b1;
    step(1, 0, 0, 0);          // start coinciding with release: ignored
    idle(3);
    step(1, 0, 0, 0);          // start -> RUN
    idle(50);
    step(0, 0, 1, 0);          // speed pickup
    idle(15);
    step(0, 0, 0, 1);          // shield pickup
    idle(5);
    step(0, 1, 0, 0);          // absorbed collision
    idle(8);
    idle(25);                  // shield long gone
    step(0, 1, 0, 0);          // unshielded collision -> GAME_OVER
    idle(4);
    step(1, 0, 0, 0);          // restart from GAME_OVER
    idle(3);
    step(0, 0, 0, 1);          // shield on, then repeated collision+pickup to saturate
    idle(2);
    for (int i = 0; i < 260; i++) begin
      step(0, 1, 0, 1);
      idle(2);
    end
    idle(25);
    step(0, 1, 0, 1);          // collision+pickup with no shield -> GAME_OVER
    idle(3);
    step(1, 0, 0, 0);
    idle(3);
    step(0, 0, 1, 0);          // speed pickup, then reset mid-REARM
    do_reset(2);
    idle(5);                   // stays IDLE without a start
    step(1, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        step($urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
             $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
      end
    end
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
